// File: rtl/p23_fifo_flags.sv
// Parametrised synchronous FIFO with an explicit level counter, programmable almost-full
// and almost-empty thresholds, sticky error flags, synchronous flush and a selectable read mode.
module p23_fifo_flags #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 16,
    parameter int AF_THRESH    = DEPTH - 1,
    parameter int AE_THRESH    = 1,
    parameter int READ_LATENCY = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic [DATA_WIDTH-1:0]     din,
    input  logic                      push,
    input  logic                      pop,
    output logic [DATA_WIDTH-1:0]     dout,
    output logic                      dout_valid,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          push_ok, pop_ok, wr_en;

    assign full         = (level_q == LW'(DEPTH));
    assign empty        = (level_q == '0);
    assign almost_full  = (level_q >= LW'(AF_THRESH));
    assign almost_empty = (level_q <= LW'(AE_THRESH));
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A pop frees a slot in the same cycle, so a push against a full FIFO still lands.
    always_comb begin
        pop_ok      = pop && !empty;
        push_ok     = push && (!full || pop_ok);
        wr_en       = push_ok && !clear;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
            if (push && !push_ok) overflow_d  = 1'b1;
            if (pop && !pop_ok)   underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= din;
    end

    if (READ_LATENCY == 0) begin : g_show_ahead
        assign dout       = mem_q[rd_ptr_q];
        assign dout_valid = !empty;
    end else begin : g_registered
        logic [DATA_WIDTH-1:0] dout_q, dout_d;
        logic                  dout_valid_q, dout_valid_d;

        always_comb begin
            dout_d       = dout_q;
            dout_valid_d = 1'b0;
            if (!clear && pop_ok) begin
                dout_d       = mem_q[rd_ptr_q];
                dout_valid_d = 1'b1;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                dout_q       <= '0;
                dout_valid_q <= 1'b0;
            end else begin
                dout_q       <= dout_d;
                dout_valid_q <= dout_valid_d;
            end
        end

        assign dout       = dout_q;
        assign dout_valid = dout_valid_q;
    end

endmodule
